// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame state, byte width, debug view and the
// CPOL/CPHA to sample/shift edge mapping used by both the responder and the master.
package spi_pkg;

   localparam int SPI_BYTE_W = 8;
   localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   typedef struct packed {
      logic sample_on_rise;
      logic shift_on_rise;
   } spi_edge_sel_t;

   typedef struct packed {
      spi_state_e           state;
      logic [SPI_CNT_W-1:0] bit_cnt;
      logic                 cs_sync;
      logic                 sclk_sync;
   } spi_dbg_t;

   // Lead edge leaves the CPOL level (rise when CPOL=0); CPHA=1 samples on trail.
   function automatic spi_edge_sel_t spi_edge_sel(input logic cpol, input logic cpha);
      spi_edge_sel_t sel;
      sel.sample_on_rise = ~(cpol ^ cpha);
      sel.shift_on_rise  = cpol ^ cpha;
      return sel;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a history flop; emits single-cycle rise/fall
// pulses by comparing the synchronized level with its previous value.
module spi_sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q <= RESET_VAL;
         s2_q <= RESET_VAL;
         s3_q <= RESET_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign sync_o = s2_q;
   assign rise_o = s2_q & ~s3_q;
   assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_byte_responder.sv
// SPI byte responder: oversampled pins, MSB-first receive, one-entry transmit
// holding register feeding a shifter that reloads at every byte boundary.
module spi_byte_responder
   import spi_pkg::*;
#(
   parameter logic                  CPOL      = 1'b1,
   parameter logic                  CPHA      = 1'b1,
   parameter logic [SPI_BYTE_W-1:0] FILL_BYTE = 8'h00
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  cs,
   input  logic                  sclk,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [SPI_BYTE_W-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [SPI_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  frame_start,
   output logic                  frame_end,
   output logic                  tx_underrun,
   output spi_dbg_t              dbg_o
);

   localparam spi_edge_sel_t EDGE_SEL = spi_edge_sel(CPOL, CPHA);
   localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_BYTE_W - 1);

   logic cs_s2, cs_rise, cs_fall;
   logic sclk_s2, sclk_rise, sclk_fall;
   logic mosi_s1_q, mosi_s2_q;

   spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
      .clk_i  (sys_clk),
      .rst_i  (sys_rst),
      .d_i    (cs),
      .sync_o (cs_s2),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
      .clk_i  (sys_clk),
      .rst_i  (sys_rst),
      .d_i    (sclk),
      .sync_o (sclk_s2),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         mosi_s1_q <= mosi;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   spi_state_e           state_q, state_d;
   logic [SPI_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [SPI_BYTE_W-1:0] rx_sh_q, rx_sh_d;
   logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
   logic [SPI_BYTE_W-1:0] tx_sh_q, tx_sh_d;
   logic [SPI_BYTE_W-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic                 skip_q, skip_d;
   logic                 miso_q, miso_d;
   logic                 miso_oe_q, miso_oe_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_start_q, frame_start_d;
   logic                 frame_end_q, frame_end_d;
   logic                 underrun_q, underrun_d;

   logic active, sample_ev, shift_ev, byte_done, frame_go, load;

   always_comb begin
      // The cs rise cycle already has cs_s2 high, so edges there are dropped.
      active    = (state_q == ST_ACTIVE) && !cs_s2;
      sample_ev = active && (EDGE_SEL.sample_on_rise ? sclk_rise : sclk_fall);
      shift_ev  = active && (EDGE_SEL.shift_on_rise ? sclk_rise : sclk_fall);
      byte_done = sample_ev && (bit_cnt_q == LAST_BIT);
      frame_go  = (state_q == ST_IDLE) && cs_fall;
      load      = frame_go || byte_done;

      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_sh_d       = rx_sh_q;
      rx_data_d     = rx_data_q;
      tx_sh_d       = tx_sh_q;
      hold_d        = hold_q;
      hold_full_d   = hold_full_q;
      skip_d        = skip_q;
      rx_valid_d    = 1'b0;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;
      underrun_d    = 1'b0;

      if (frame_go) begin
         state_d       = ST_ACTIVE;
         bit_cnt_d     = '0;
         frame_start_d = 1'b1;
      end

      if (cs_rise) begin
         state_d     = ST_IDLE;
         bit_cnt_d   = '0;
         frame_end_d = 1'b1;
      end

      if (sample_ev) begin
         rx_sh_d   = {rx_sh_q[SPI_BYTE_W-2:0], mosi_s2_q};
         bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
         if (byte_done) begin
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
         end
      end

      if (shift_ev) begin
         if (skip_q) begin
            skip_d = 1'b0;
         end else begin
            tx_sh_d = {tx_sh_q[SPI_BYTE_W-2:0], 1'b0};
         end
      end

      // For CPHA=0 the first shift edge of a frame already moves to bit 6,
      // so only CPHA=1 frame starts and every byte-boundary reload skip it.
      if (load) begin
         tx_sh_d     = hold_full_q ? hold_q : FILL_BYTE;
         underrun_d  = !hold_full_q;
         hold_full_d = 1'b0;
         skip_d      = CPHA || byte_done;
      end

      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      miso_oe_d = (state_d == ST_ACTIVE);
      miso_d    = miso_oe_d ? tx_sh_d[SPI_BYTE_W-1] : 1'b0;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         rx_sh_q       <= '0;
         rx_data_q     <= '0;
         tx_sh_q       <= '0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         skip_q        <= 1'b0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         rx_valid_q    <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_sh_q       <= rx_sh_d;
         rx_data_q     <= rx_data_d;
         tx_sh_q       <= tx_sh_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         skip_q        <= skip_d;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         rx_valid_q    <= rx_valid_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
         underrun_q    <= underrun_d;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = miso_oe_q;
   assign tx_ready    = !hold_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign tx_underrun = underrun_q;

   assign dbg_o.state     = state_q;
   assign dbg_o.bit_cnt   = bit_cnt_q;
   assign dbg_o.cs_sync   = cs_s2;
   assign dbg_o.sclk_sync = sclk_s2;

endmodule
